// File: rtl/dispatch_arbiter_pkg.sv
// Packet-format definitions shared by network_source, the dispatch arbiter,
// packet sinks and testbenches.

package source_config;
    localparam int PFX_WIDTH = 4;
endpackage

package dispatch_config;
    localparam int PFX_WIDTH = source_config::PFX_WIDTH;

    typedef enum logic [PFX_WIDTH-1:0] {
        NOP = 4'h0,
        SPK = 4'h1,
        RUN = 4'h2,
        SNC = 4'h3,
        CLR = 4'h4,
        CFG = 4'h5
    } opcode_t;

    // Opcodes that close a timestep frame; unlisted encodings keep the frame open.
    function automatic logic is_frame_end(input opcode_t op);
        case (op)
            RUN, SNC, CLR: return 1'b1;
            default:       return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/dispatch_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.

module rr_pick #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_valid
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // NOTE: every output and temporary gets a default at the top of the block,
    // otherwise paths that skip an assignment infer latches.
    always_comb begin
        grant     = ptr;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        // Scan from the far end so the candidate nearest ptr is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (req[idx]) begin
                grant     = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dispatch_arbiter.sv
// Frame-locked round-robin arbiter sharing one network_source packet port
// between NUM_REQ requesters, with a registered output stage.

module dispatch_arbiter
    import source_config::*;
    import dispatch_config::opcode_t;
    import dispatch_config::is_frame_end;
#(
    parameter  int PKT_WIDTH    = 16,
    parameter  int NUM_REQ      = 2,
    parameter  int LOCK_TIMEOUT = 1024,
    localparam int OWN_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [PKT_WIDTH-1:0] req_pkt [NUM_REQ],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PKT_WIDTH-1:0] out_pkt,
    output logic [OWN_W-1:0]     owner,
    output logic                 locked,
    output logic                 timeout_evt
);

    localparam bit             TIMEOUT_EN = (LOCK_TIMEOUT > 0);
    localparam int             CNT_W      = TIMEOUT_EN ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_TIMEOUT);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t               state_q, state_d;
    logic [OWN_W-1:0]     owner_q, owner_d;
    logic [OWN_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [PKT_WIDTH-1:0] out_pkt_q, out_pkt_d;
    logic                 timeout_evt_q, timeout_evt_d;

    logic [OWN_W-1:0]     pick_idx, grant_idx;
    logic                 pick_any, grant_ok;
    logic                 can_load, expire, fire, sel_end;
    logic [PKT_WIDTH-1:0] sel_pkt;

    function automatic logic [OWN_W-1:0] next_idx(input logic [OWN_W-1:0] idx);
        return (int'(idx) >= NUM_REQ - 1) ? '0 : idx + OWN_W'(1);
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (pick_idx),
        .any_valid (pick_any)
    );

    // Grant path: the owner is the only candidate while locked, except in the
    // expiry cycle where nobody is offered the port.
    always_comb begin
        can_load = !out_valid_q || out_ready;
        expire   = TIMEOUT_EN && (state_q == ST_LOCKED) && (idle_cnt_q == CNT_MAX);
        if (state_q == ST_LOCKED) begin
            grant_idx = owner_q;
            grant_ok  = !expire;
        end else begin
            grant_idx = pick_idx;
            grant_ok  = pick_any;
        end
        req_ready            = '0;
        req_ready[grant_idx] = grant_ok && can_load;
        fire    = req_valid[grant_idx] && grant_ok && can_load;
        sel_pkt = req_pkt[grant_idx];
        sel_end = is_frame_end(opcode_t'(sel_pkt[PKT_WIDTH-1 -: PFX_WIDTH]));
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        idle_cnt_d    = idle_cnt_q;
        out_valid_d   = out_valid_q;
        out_pkt_d     = out_pkt_q;
        timeout_evt_d = 1'b0;

        if (fire) begin
            out_valid_d = 1'b1;
            out_pkt_d   = sel_pkt;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    owner_d = grant_idx;
                    if (sel_end) begin
                        rr_ptr_d = next_idx(grant_idx);
                    end else begin
                        state_d    = ST_LOCKED;
                        idle_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (expire) begin
                    state_d       = ST_IDLE;
                    rr_ptr_d      = next_idx(owner_q);
                    idle_cnt_d    = '0;
                    timeout_evt_d = 1'b1;
                end else if (fire && sel_end) begin
                    state_d    = ST_IDLE;
                    rr_ptr_d   = next_idx(owner_q);
                    idle_cnt_d = '0;
                end else if (req_valid[owner_q]) begin
                    idle_cnt_d = '0;
                end else if (TIMEOUT_EN && (idle_cnt_q != CNT_MAX)) begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            idle_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            out_pkt_q     <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            idle_cnt_q    <= idle_cnt_d;
            out_valid_q   <= out_valid_d;
            out_pkt_q     <= out_pkt_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pkt     = out_pkt_q;
    assign owner       = owner_q;
    assign locked      = (state_q == ST_LOCKED);
    assign timeout_evt = timeout_evt_q;

endmodule
